// File: rtl/stage_trace.sv
// Retirement trace buffer: captures {pc, instr, opc, tick} into a FIFO while armed, with PC-match trigger and post-trigger window.
// Head entry visible one cycle after push (no fall-through); pushes into a full FIFO without a pop are dropped and counted.

module stage_trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdat,
  output logic [W-1:0]  rdat,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr && push_ok) mem[wr_ptr_q] <= wdat;
  end

  // Storage is not reset; masking keeps the head fields at zero while empty.
  assign rdat  = empty ? '0 : mem[rd_ptr_q];
  assign count = count_q;
endmodule

module stage_trace #(
  parameter int ADDR_WIDTH  = 24,
  parameter int INSTR_WIDTH = 24,
  parameter int OPC_WIDTH   = 8,
  parameter int DEPTH       = 16,
  parameter int POST_DEPTH  = 4
) (
  input  logic                     iw_clk,
  input  logic                     iw_rst,
  input  logic                     iw_wb_valid,
  input  logic [ADDR_WIDTH-1:0]    iw_wb_pc,
  input  logic [INSTR_WIDTH-1:0]   iw_wb_instr,
  input  logic [OPC_WIDTH-1:0]     iw_wb_opc,
  input  logic                     iw_arm,
  input  logic                     iw_clear,
  input  logic                     iw_trig_en,
  input  logic [ADDR_WIDTH-1:0]    iw_trig_pc,
  input  logic                     iw_rd_ready,
  output logic                     ow_rd_valid,
  output logic [ADDR_WIDTH-1:0]    ow_rd_pc,
  output logic [INSTR_WIDTH-1:0]   ow_rd_instr,
  output logic [OPC_WIDTH-1:0]     ow_rd_opc,
  output logic [31:0]              ow_rd_tick,
  output logic [$clog2(DEPTH):0]   ow_count,
  output logic [1:0]               ow_state,
  output logic                     ow_overflow,
  output logic [15:0]              ow_drop_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (POST_DEPTH > 0) ? $clog2(POST_DEPTH + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_POST = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic [OPC_WIDTH-1:0]   opc;
    logic [31:0]            tick;
  } entry_t;

  logic [31:0]   tick_q, tick_d;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] post_q, post_d;
  logic [15:0]   drop_q, drop_d;
  logic          ovf_q, ovf_d;

  entry_t        wr_ent;
  entry_t        rd_ent;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          capture;
  logic          pop;
  logic          drop;
  logic          trig_hit;

  assign capture  = iw_wb_valid && ((state_q == S_RUN) || (state_q == S_POST));
  assign pop      = !fifo_empty && iw_rd_ready;
  assign drop     = capture && fifo_full && !pop;
  assign trig_hit = capture && iw_trig_en && (iw_wb_pc == iw_trig_pc);

  always_comb begin
    wr_ent       = '0;
    wr_ent.pc    = iw_wb_pc;
    wr_ent.instr = iw_wb_instr;
    wr_ent.opc   = iw_wb_opc;
    wr_ent.tick  = tick_q;
  end

  stage_trace_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (iw_clk),
    .rst   (iw_rst),
    .clr   (iw_clear),
    .push  (capture),
    .pop   (pop),
    .wdat  (wr_ent),
    .rdat  (rd_ent),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    tick_d  = tick_q + 32'd1;
    state_d = state_q;
    post_d  = post_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    if (iw_clear) begin
      state_d = S_IDLE;
      post_d  = '0;
      drop_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
      case (state_q)
        S_IDLE, S_HALT: begin
          if (iw_arm) state_d = S_RUN;
        end
        S_RUN: begin
          // The trigger entry itself is outside the post-trigger window.
          if (trig_hit) begin
            post_d  = PW'(POST_DEPTH);
            state_d = (POST_DEPTH == 0) ? S_HALT : S_POST;
          end
        end
        S_POST: begin
          if (capture) begin
            post_d = post_q - PW'(1);
            if (post_q == PW'(1)) state_d = S_HALT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      tick_q  <= '0;
      state_q <= S_IDLE;
      post_q  <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      state_q <= state_d;
      post_q  <= post_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ow_rd_valid = !fifo_empty;
  assign ow_rd_pc    = rd_ent.pc;
  assign ow_rd_instr = rd_ent.instr;
  assign ow_rd_opc   = rd_ent.opc;
  assign ow_rd_tick  = rd_ent.tick;
  assign ow_count    = fifo_count;
  assign ow_state    = state_q;
  assign ow_overflow = ovf_q;
  assign ow_drop_cnt = drop_q;
endmodule

// File: tb/tb_stage_trace.sv
// Bench for stage_trace: queue-based reference model checked every cycle, plus directed literal checks.
module tb_stage_trace;
  localparam int DEPTH = 16;
  localparam int POSTD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [23:0] wb_pc = '0;
  logic [23:0] wb_instr = '0;
  logic [7:0]  wb_opc = '0;
  logic        arm = 1'b0;
  logic        clear = 1'b0;
  logic        trig_en = 1'b0;
  logic [23:0] trig_pc = '0;
  logic        rd_ready = 1'b0;

  logic        rd_valid;
  logic [23:0] rd_pc;
  logic [23:0] rd_instr;
  logic [7:0]  rd_opc;
  logic [31:0] rd_tick;
  logic [4:0]  count;
  logic [1:0]  state;
  logic        overflow;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  stage_trace #(
    .ADDR_WIDTH(24), .INSTR_WIDTH(24), .OPC_WIDTH(8), .DEPTH(DEPTH), .POST_DEPTH(POSTD)
  ) dut (
    .iw_clk(clk), .iw_rst(rst), .iw_wb_valid(wb_valid), .iw_wb_pc(wb_pc),
    .iw_wb_instr(wb_instr), .iw_wb_opc(wb_opc), .iw_arm(arm), .iw_clear(clear),
    .iw_trig_en(trig_en), .iw_trig_pc(trig_pc), .iw_rd_ready(rd_ready),
    .ow_rd_valid(rd_valid), .ow_rd_pc(rd_pc), .ow_rd_instr(rd_instr), .ow_rd_opc(rd_opc),
    .ow_rd_tick(rd_tick), .ow_count(count), .ow_state(state), .ow_overflow(overflow),
    .ow_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entries as a queue, state as small integers (0 idle, 1 run, 2 post, 3 halt).
  typedef struct packed {
    logic [23:0] pc;
    logic [23:0] instr;
    logic [7:0]  opc;
    logic [31:0] tick;
  } ent_t;

  ent_t        mq[$];
  int          m_state = 0;
  int          m_post  = 0;
  int          m_drop  = 0;
  bit          m_ovf   = 1'b0;
  logic [31:0] m_tick  = '0;

  always @(posedge clk) begin
    ent_t e;
    bit   do_pop;
    bit   cap;
    if (rst) begin
      mq.delete();
      m_state = 0; m_post = 0; m_drop = 0; m_ovf = 1'b0; m_tick = '0;
    end else begin
      do_pop = (mq.size() != 0) && rd_ready;
      cap    = wb_valid && (m_state == 1 || m_state == 2);
      if (clear) begin
        mq.delete();
        m_state = 0; m_post = 0; m_drop = 0; m_ovf = 1'b0;
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (cap) begin
          if (mq.size() < DEPTH) begin
            e.pc = wb_pc; e.instr = wb_instr; e.opc = wb_opc; e.tick = m_tick;
            mq.push_back(e);
          end else begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
          end
        end
        if ((m_state == 0 || m_state == 3) && arm) m_state = 1;
        else if (m_state == 1 && cap && trig_en && wb_pc == trig_pc) begin
          m_post  = POSTD;
          m_state = (POSTD == 0) ? 3 : 2;
        end else if (m_state == 2 && cap) begin
          m_post--;
          if (m_post == 0) m_state = 3;
        end
      end
      m_tick = m_tick + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_valid", rd_valid, mq.size() != 0);
      check("cyc_count", count, mq.size());
      check("cyc_state", state, m_state);
      check("cyc_ovf", overflow, m_ovf);
      check("cyc_drop", drop_cnt, m_drop);
      if (mq.size() != 0) begin
        check("cyc_pc", rd_pc, mq[0].pc);
        check("cyc_instr", rd_instr, mq[0].instr);
        check("cyc_opc", rd_opc, mq[0].opc);
        check("cyc_tick", rd_tick, mq[0].tick);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [23:0] pc);
    wb_valid = 1'b1;
    wb_pc    = pc;
    wb_instr = pc ^ 24'h5A5A5A;
    wb_opc   = pc[7:0] + 8'd1;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  initial begin
    logic [31:0] prev_tick;
    rst = 1'b1;
    step(); step();
    chk_en = 1'b1;
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_state", state, 0);
    check("rst_pc", rd_pc, 0);
    check("rst_tick", rd_tick, 0);
    check("rst_drop", drop_cnt, 0);
    rst = 1'b0;

    // Three retirements, consumer stalled
    pulse_arm();
    check("arm_run", state, 1);
    check("pre_push_valid", rd_valid, 0);
    retire(24'h000010);
    check("valid_after_push", rd_valid, 1);
    retire(24'h000011);
    retire(24'h000012);
    check("three_count", count, 3);
    check("three_head", rd_pc, 24'h000010);

    // Overflow: 20 retirements into a 16-deep FIFO
    pulse_clear();
    check("clear_idle", state, 0);
    pulse_arm();
    for (int i = 0; i < 20; i++) retire(24'h000100 + 24'(i));
    check("ovf_count", count, 16);
    check("ovf_drop", drop_cnt, 4);
    check("ovf_flag", overflow, 1);

    // Full with simultaneous push and pop
    wb_valid = 1'b1; wb_pc = 24'h000200; wb_instr = 24'h000200 ^ 24'h5A5A5A; wb_opc = 8'h01;
    rd_ready = 1'b1;
    step();
    wb_valid = 1'b0; rd_ready = 1'b0;
    check("full_pp_count", count, 16);
    check("full_pp_drop", drop_cnt, 4);

    // Drain in order with increasing timestamps
    prev_tick = '0;
    for (int i = 0; i < 16; i++) begin
      check("drain_pc", rd_pc, (i < 15) ? (24'h000101 + 24'(i)) : 24'h000200);
      if (i > 0) check("drain_tick_inc", rd_tick > prev_tick, 1);
      prev_tick = rd_tick;
      rd_ready = 1'b1;
      step();
    end
    rd_ready = 1'b0;
    check("drained_valid", rd_valid, 0);

    // PC trigger with a four-entry post window
    pulse_clear();
    pulse_arm();
    trig_en = 1'b1; trig_pc = 24'h000020;
    for (int p = 24'h1E; p <= 24'h28; p++) begin
      retire(24'(p));
      if (p == 24'h20) check("trig_post", state, 2);
    end
    check("trig_halt", state, 3);
    check("trig_count", count, 7);
    check("trig_drop", drop_cnt, 0);
    trig_en = 1'b0;
    pulse_arm();
    check("halt_rearm", state, 1);
    check("rearm_keep", count, 7);
    for (int i = 0; i < 7; i++) begin
      check("trig_order", rd_pc, 24'h00001E + 24'(i));
      rd_ready = 1'b1;
      step();
    end
    rd_ready = 1'b0;

    // Clear beats arm, push and pop in the same cycle
    for (int i = 0; i < 5; i++) retire(24'h000300 + 24'(i));
    check("five_count", count, 5);
    clear = 1'b1; arm = 1'b1; wb_valid = 1'b1; wb_pc = 24'h000400; rd_ready = 1'b1;
    step();
    clear = 1'b0; arm = 1'b0; wb_valid = 1'b0; rd_ready = 1'b0;
    check("clr_state", state, 0);
    check("clr_count", count, 0);
    check("clr_valid", rd_valid, 0);

    // Reset during the post window
    pulse_arm();
    trig_en = 1'b1; trig_pc = 24'h000040;
    for (int p = 24'h3A; p <= 24'h40; p++) retire(24'(p));
    check("post_state", state, 2);
    check("post_count", count, 7);
    rst = 1'b1; clear = 1'b1; wb_valid = 1'b1; wb_pc = 24'h000041;
    step();
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_state", state, 0);
    check("mid_rst_pc", rd_pc, 0);
    check("mid_rst_instr", rd_instr, 0);
    check("mid_rst_opc", rd_opc, 0);
    check("mid_rst_tick", rd_tick, 0);
    rst = 1'b0; clear = 1'b0; wb_valid = 1'b0; trig_en = 1'b0;
    pulse_arm();
    retire(24'h000055);
    check("post_rst_pc", rd_pc, 24'h000055);
    check("post_rst_tick", rd_tick, 1);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
